// File: rtl/ram_access_pkg.sv
// Shared types and constants for the RAM access controller: transfer size codes,
// controller states and the byte-lane mask helper.
package ram_access_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_MERGE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr_lo;
      SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// Combinational lane logic: picks and extends the addressed lane for loads and
// splices store data into the old word for sub-word stores.
module ram_lane_unit
  import ram_access_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]        rd_lane [4];
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] wr_lanes;
  logic [3:0]        mask;

  assign mask = lane_mask(addr_lo, size);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi]            = rd_word[8*gi +: 8];
      assign merge_data[8*gi +: 8]  = mask[gi] ? wr_lanes[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = rd_lane[addr_lo];
  assign ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  // Store data is right-justified; replicate it so every candidate lane sees it.
  always_comb begin
    case (size)
      SZ_BYTE: wr_lanes = {4{wdata[7:0]}};
      SZ_HALF: wr_lanes = {2{wdata[15:0]}};
      default: wr_lanes = wdata;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// CPU load/store front end for a single-port word RAM: access checking,
// read-modify-write for sub-word stores, load extension and post-reset zero-fill.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  output logic              ram_wea,
  output logic              ram_rsta,
  input  logic [31:0]       ram_douta
);

  localparam logic [ADDR_W-1:0] LAST_WORD   = '1;
  localparam state_e            RESET_STATE = (INIT_CLEAR != 1'b0) ? ST_INIT : ST_IDLE;

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       old_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              access_err;
  logic              word_store;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              wea_comb;

  ram_lane_unit u_lane (
    .addr_lo     (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .rd_word     (ram_douta),
    .old_word    (old_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  assign word_addr  = addr_reg[ADDR_W+1:2];
  assign word_store = we_reg && (size_reg == SZ_WORD);

  // Size, alignment and range are all judged on the latched request.
  always_comb begin
    access_err = 1'b0;
    if (size_reg == SZ_ILL)
      access_err = 1'b1;
    else if ((size_reg == SZ_HALF) && addr_reg[0])
      access_err = 1'b1;
    else if ((size_reg == SZ_WORD) && (addr_reg[1:0] != 2'b00))
      access_err = 1'b1;
    else if ((addr_reg >> (ADDR_W + 2)) != 32'd0)
      access_err = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:   if (cnt_reg == LAST_WORD) state_next = ST_IDLE;
      ST_IDLE:   if (req_valid) state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (access_err)
          state_next = ST_RESP;
        else if (we_reg && !word_store)
          state_next = ST_MERGE;
        else
          state_next = ST_RESP;
      end
      ST_MERGE:  state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      old_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_INIT)
        cnt_reg <= cnt_reg + 1'b1;
      if ((state_reg == ST_IDLE) && req_valid) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_ACCESS) begin
        err_reg   <= access_err;
        rdata_reg <= (!access_err && !we_reg) ? load_data : 32'd0;
        old_reg   <= ram_douta;
      end
    end
  end

  // RAM port is driven straight from state so a load sees ram_douta in ACCESS.
  always_comb begin
    wea_comb  = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    case (state_reg)
      ST_INIT: begin
        wea_comb  = 1'b1;
        ram_addra = cnt_reg;
      end
      ST_ACCESS: begin
        ram_addra = word_addr;
        if (word_store && !access_err) begin
          wea_comb = 1'b1;
          ram_dina = wdata_reg;
        end
      end
      ST_MERGE: begin
        wea_comb  = 1'b1;
        ram_addra = word_addr;
        ram_dina  = merge_data;
      end
      default: ;
    endcase
  end

  // Gating with reset keeps the RAM untouched and the handshake closed while held.
  assign ram_wea   = wea_comb && rsta_n;
  assign req_ready = (state_reg == ST_IDLE) && rsta_n;
  assign rsp_valid = (state_reg == ST_RESP);
  assign init_busy = (state_reg == ST_INIT);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign ram_rsta  = 1'b0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 64x32 RAM model.
module tb_ram_access_ctrl;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        init_busy;
  logic [5:0]  ram_addra;
  logic [31:0] ram_dina, ram_douta;
  logic        ram_wea, ram_rsta;

  always #5 clka = ~clka;

  ram_access_ctrl #(.ADDR_W(6), .INIT_CLEAR(1'b1)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_busy(init_busy),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_rsta(ram_rsta), .ram_douta(ram_douta)
  );

  // RAM model: combinational read, write on rising edge
  logic [31:0] mem [64];
  logic [63:0] seen;
  logic        fill_req = 1'b0;
  int          wr_count = 0;

  assign ram_douta = mem[ram_addra];

  always @(posedge clka) begin
    if (fill_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 + i;
      seen <= '0;
    end else if (ram_wea) begin
      mem[ram_addra] <= ram_dina;
      wr_count       <= wr_count + 1;
      if (init_busy && ram_dina == 32'd0) seen[ram_addra] <= 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // lat = number of falling edges after the accept edge until rsp_valid is seen
  task automatic run_req(input vec_t v, output logic [31:0] rdata, output logic err,
                         output int lat, output int wr_delta, output bit ok);
    int n;
    int w0;
    ok = 1'b1; lat = 0; rdata = '0; err = 1'b0; wr_delta = 0;
    @(negedge clka);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clka); n++; end
    if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
    w0 = wr_count;
    @(posedge clka);
    @(negedge clka);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clka); lat++; end
    if (!rsp_valid) begin ok = 1'b0; return; end
    rdata = rsp_rdata; err = rsp_err; wr_delta = wr_count - w0;
    @(posedge clka);
  endtask

  task automatic wait_init(input string tag);
    int cyc;
    int w0;
    int nz;
    w0 = wr_count;
    cyc = 0;
    while (init_busy && cyc < 200) begin @(posedge clka); @(negedge clka); cyc++; end
    chk({tag, "_init_cycles"}, 32'(cyc), 32'd64);
    chk({tag, "_init_writes"}, 32'(wr_count - w0), 32'd64);
    chk({tag, "_init_cover"}, 32'($countones(seen)), 32'd64);
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 32'd0) nz++;
    chk({tag, "_ram_zero"}, 32'(nz), 32'd0);
    chk({tag, "_ready_after_init"}, {31'd0, req_ready}, 32'd1);
    $display("init %s: %0d cycles, %0d writes", tag, cyc, wr_count - w0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    chk({tag, "_ram_wea"},   {31'd0, ram_wea}, 32'd0);
    chk({tag, "_ram_addra"}, {26'd0, ram_addra}, 32'd0);
    chk({tag, "_ram_dina"},  ram_dina, 32'd0);
    chk({tag, "_init_busy"}, {31'd0, init_busy}, 32'd1);
    chk({tag, "_ram_rsta"},  {31'd0, ram_rsta}, 32'd0);
  endtask

  vec_t vtab[$];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, wd, w0;
    bit          ok;
    vec_t        v;

    // we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat
    vtab.push_back(mk(0, 2'b10, 0, 32'h00, 32'h0,        32'h00000000, 0, 2));
    vtab.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 2));
    vtab.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2));
    vtab.push_back(mk(1, 2'b00, 0, 32'h12, 32'h0000005A, 32'h00000000, 0, 3));
    vtab.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDE5ABEEF, 0, 2));
    vtab.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2));
    vtab.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0,        32'h0000DE5A, 0, 2));
    vtab.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFDE5A, 0, 2));
    vtab.push_back(mk(0, 2'b00, 1, 32'h10, 32'h0,        32'h000000EF, 0, 2));
    vtab.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0,        32'hFFFFFFBE, 0, 2));
    vtab.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,        32'h000000DE, 0, 2));
    vtab.push_back(mk(1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h00000000, 0, 3));
    vtab.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hABCD0000, 0, 2));
    vtab.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFFABCD, 0, 2));
    vtab.push_back(mk(1, 2'b01, 0, 32'h10, 32'hFFFF7711, 32'h00000000, 0, 3));
    vtab.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDE5A7711, 0, 2));
    vtab.push_back(mk(1, 2'b00, 0, 32'hFC, 32'h00000080, 32'h00000000, 0, 3));
    vtab.push_back(mk(0, 2'b00, 0, 32'hFC, 32'h0,        32'hFFFFFF80, 0, 2));
    vtab.push_back(mk(0, 2'b10, 0, 32'hFC, 32'h0,        32'h00000080, 0, 2));
    vtab.push_back(mk(0, 2'b01, 0, 32'h11, 32'h0,        32'h00000000, 1, 2));
    vtab.push_back(mk(1, 2'b10, 0, 32'h02, 32'h11111111, 32'h00000000, 1, 2));
    vtab.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0,        32'h00000000, 1, 2));
    vtab.push_back(mk(1, 2'b11, 0, 32'h10, 32'h22222222, 32'h00000000, 1, 2));
    vtab.push_back(mk(1, 2'b10, 0, 32'h100, 32'h33333333, 32'h00000000, 1, 2));
    vtab.push_back(mk(1, 2'b00, 0, 32'h100, 32'h44,      32'h00000000, 1, 2));
    vtab.push_back(mk(0, 2'b00, 0, 32'hFFFFFFFF, 32'h0,  32'h00000000, 1, 2));
    vtab.push_back(mk(1, 2'b01, 0, 32'h13, 32'h5555,     32'h00000000, 1, 2));
    vtab.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDE5A7711, 0, 2));
    vtab.push_back(mk(0, 2'b10, 0, 32'h00, 32'h0,        32'h00000000, 0, 2));

    rsta_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    fill_req = 1'b1;
    @(posedge clka);
    @(negedge clka);
    fill_req = 1'b0;
    chk_reset_vals("reset");

    rsta_n = 1'b1;
    wait_init("por");

    foreach (vtab[k]) begin
      v = vtab[k];
      run_req(v, rd, er, lat, wd, ok);
      $display("txn %0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d writes=%0d",
               k, v.we, v.size, v.uns, v.addr, v.wdata, rd, er, lat, wd);
      chk($sformatf("v%0d_handshake", k), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
      chk($sformatf("v%0d_err", k), {31'd0, er}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_writes", k), 32'(wd), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    end

    // Backpressure: response held for 5 cycles with rsp_ready low
    @(negedge clka);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; rsp_ready = 1'b0;
    chk("bp_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clka);
    @(negedge clka);
    req_valid = 1'b0;
    @(posedge clka);
    @(negedge clka);
    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clka);
      @(negedge clka);
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", c), rsp_rdata, 32'hDE5A7711);
      chk($sformatf("bp_hold%0d_ready", c), {31'd0, req_ready}, 32'd0);
    end
    $display("txn bp load addr=0x00000010 rdata=0x%08h held 5 cycles", rsp_rdata);
    rsp_ready = 1'b1;
    @(posedge clka);
    @(negedge clka);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset while a byte store sits in MERGE
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h33;
    @(posedge clka);
    @(negedge clka);
    req_valid = 1'b0;
    @(posedge clka);
    @(negedge clka);
    chk("merge_wea_before_reset", {31'd0, ram_wea}, 32'd1);
    w0 = wr_count;
    rsta_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(posedge clka);
    @(negedge clka);
    chk("mid_reset_no_write", 32'(wr_count - w0), 32'd0);
    chk("mid_reset_word_kept", mem[4], 32'hDE5A7711);
    $display("txn reset-in-merge store byte addr=0x00000010 writes=%0d", wr_count - w0);
    rsta_n = 1'b1;
    wait_init("rerun");
    run_req(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 2), rd, er, lat, wd, ok);
    $display("txn post-reset load addr=0x00000010 rdata=0x%08h err=%0d lat=%0d", rd, er, lat);
    chk("post_reset_handshake", {31'd0, ok}, 32'd1);
    chk("post_reset_rdata", rd, 32'd0);
    chk("post_reset_latency", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
